// File: rtl/timetag_pkg.sv
// Shared definitions for the timetagger control path.
// Holds the command/reply framing constants and the command engine state type.
package timetag_pkg;

    // Framing bytes, opcodes and status codes of the host command protocol
    localparam logic [7:0] SYNC_REQ  = 8'hAA;
    localparam logic [7:0] SYNC_RPL  = 8'h55;
    localparam logic [7:0] OPC_RD    = 8'h01;
    localparam logic [7:0] OPC_WR    = 8'h02;
    localparam logic [7:0] ST_OK     = 8'h00;
    localparam logic [7:0] ST_BADOPC = 8'hEE;

    // Reply frame lengths in bytes
    localparam logic [2:0] RPL_LEN_SHORT = 3'd3;
    localparam logic [2:0] RPL_LEN_LONG  = 3'd6;

    // Command engine states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OPC   = 3'd1,
        S_ADDR  = 3'd2,
        S_DATA  = 3'd3,
        S_EXEC  = 3'd4,
        S_RWAIT = 3'd5,
        S_REPLY = 3'd6
    } state_e;

endpackage

// File: rtl/cmd_reg_engine_if.sv
// Bundle of the command byte stream, reply port and register bus around the
// command/register engine.
//   slave  : the engine side (consumes commands, produces replies, masters the
//            register bus through its outputs)
//   master : the surrounding side (FX2 interface, register file, testbench)
interface cmd_reg_engine_if;
    logic [7:0]  cmd;
    logic        cmd_wr;
    logic [7:0]  reply;
    logic        reply_rdy;
    logic        reply_ack;
    logic        reply_end;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_wr;
    logic        reg_rd;
    logic [31:0] reg_rdata;

    modport slave (
        input  cmd, cmd_wr, reply_ack, reg_rdata,
        output reply, reply_rdy, reply_end, reg_addr, reg_wdata, reg_wr, reg_rd
    );

    modport master (
        output cmd, cmd_wr, reply_ack, reg_rdata,
        input  reply, reply_rdy, reply_end, reg_addr, reg_wdata, reg_wr, reg_rd
    );
endinterface

// File: rtl/cmd_reg_engine_reply_serializer.sv
// Reply serializer: holds one reply frame (up to 6 bytes) and presents it byte
// by byte under a ready/ack handshake.
//   clk, rst_n         : clock, async active-low reset
//   load               : capture load_buf/load_len and start presenting byte 0
//   load_buf[k]        : byte k of the frame (byte 0 goes out first)
//   load_len           : frame length, 3 or 6
//   reply_ack          : consumer accepts the presented byte
//   reply/_rdy/_end    : registered byte, valid flag, last-byte flag
//   done               : the last byte transfers this cycle
module reply_serializer (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [5:0][7:0] load_buf,
    input  logic [2:0]      load_len,
    input  logic            reply_ack,
    output logic [7:0]      reply,
    output logic            reply_rdy,
    output logic            reply_end,
    output logic            done
);
    logic [5:0][7:0] frame_q, frame_d;
    logic [2:0]      len_q, len_d;
    logic [2:0]      idx_q, idx_d;
    logic [2:0]      idx_nxt;
    logic [7:0]      byte_q, byte_d;
    logic            rdy_q, rdy_d;
    logic            end_q, end_d;

    // Next-state: load a frame, or step to the next byte on each transfer
    always_comb begin
        frame_d = frame_q;
        len_d   = len_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        rdy_d   = rdy_q;
        end_d   = end_q;
        idx_nxt = idx_q + 3'd1;
        if (load) begin
            frame_d = load_buf;
            len_d   = load_len;
            idx_d   = 3'd0;
            byte_d  = load_buf[0];
            rdy_d   = 1'b1;
            end_d   = 1'b0;
        end else if (rdy_q && reply_ack) begin
            if (end_q) begin
                // Final byte taken: drop ready the following cycle
                idx_d  = 3'd0;
                byte_d = 8'h00;
                rdy_d  = 1'b0;
                end_d  = 1'b0;
            end else begin
                idx_d  = idx_nxt;
                byte_d = frame_q[idx_nxt];
                end_d  = (idx_nxt == (len_q - 3'd1));
            end
        end else begin
            rdy_d = rdy_q;
        end
    end

    // Frame buffer and registered reply outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
            len_q   <= 3'd0;
            idx_q   <= 3'd0;
            byte_q  <= 8'h00;
            rdy_q   <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            frame_q <= frame_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            rdy_q   <= rdy_d;
            end_q   <= end_d;
        end
    end

    assign reply     = byte_q;
    assign reply_rdy = rdy_q;
    assign reply_end = end_q;
    assign done      = rdy_q & reply_ack & end_q;
endmodule

// File: rtl/cmd_reg_engine.sv
// Command/register engine: frames host command bytes (AA opc addr [d0..d3])
// into 32-bit register reads/writes and returns a framed reply per command.
//   fx2_clk, rst_n : sole clock, async active-low reset
//   bus (slave)    : cmd/cmd_wr in, reply/reply_rdy/reply_end out with
//                    reply_ack in, register bus reg_addr/reg_wdata/reg_wr/
//                    reg_rd out with reg_rdata in (valid one cycle after reg_rd)
//   timeout_cnt    : saturating count of frames abandoned for inactivity
module cmd_reg_engine
    import timetag_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input  logic             fx2_clk,
    input  logic             rst_n,
    cmd_reg_engine_if.slave  bus,
    output logic [7:0]       timeout_cnt
);
    localparam int             TO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [7:0]      opc_q, opc_d;
    logic [7:0]      addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [1:0]      bidx_q, bidx_d;
    logic [TO_W-1:0] tcnt_q, tcnt_d;
    logic [7:0]      tocnt_q, tocnt_d;
    logic            reg_wr_q, reg_wr_d;
    logic            reg_rd_q, reg_rd_d;
    logic            timed_out;
    logic            ser_load;
    logic [5:0][7:0] ser_buf;
    logic [2:0]      ser_len;
    logic            ser_done;

    // Frame decoder, timeout watchdog and reply loading
    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        bidx_d    = bidx_q;
        tcnt_d    = '0;
        tocnt_d   = tocnt_q;
        reg_wr_d  = 1'b0;
        reg_rd_d  = 1'b0;
        timed_out = 1'b0;
        ser_load  = 1'b0;
        ser_buf   = '0;
        ser_len   = RPL_LEN_SHORT;

        // Inactivity counter only runs while a request frame is half-received;
        // a byte arriving on the terminal count still wins.
        if ((state_q == S_OPC) || (state_q == S_ADDR) || (state_q == S_DATA)) begin
            if (bus.cmd_wr) begin
                tcnt_d = '0;
            end else if (tcnt_q == TO_LAST) begin
                tcnt_d    = '0;
                timed_out = 1'b1;
            end else begin
                tcnt_d = tcnt_q + TO_W'(1);
            end
        end else begin
            tcnt_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_wr && (bus.cmd == SYNC_REQ)) begin
                    state_d = S_OPC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OPC: begin
                if (bus.cmd_wr) begin
                    opc_d = bus.cmd;
                    if ((bus.cmd == OPC_RD) || (bus.cmd == OPC_WR)) begin
                        state_d = S_ADDR;
                    end else begin
                        ser_load = 1'b1;
                        ser_buf  = {8'h00, 8'h00, 8'h00, ST_BADOPC, bus.cmd, SYNC_RPL};
                        state_d  = S_REPLY;
                    end
                end else begin
                    state_d = S_OPC;
                end
            end
            S_ADDR: begin
                if (bus.cmd_wr) begin
                    addr_d = bus.cmd;
                    if (opc_q == OPC_WR) begin
                        bidx_d  = 2'd0;
                        state_d = S_DATA;
                    end else begin
                        reg_rd_d = 1'b1;
                        state_d  = S_EXEC;
                    end
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_DATA: begin
                if (bus.cmd_wr) begin
                    wdata_d[{bidx_q, 3'b000} +: 8] = bus.cmd;
                    if (bidx_q == 2'd3) begin
                        reg_wr_d = 1'b1;
                        state_d  = S_EXEC;
                    end else begin
                        bidx_d = bidx_q + 2'd1;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_EXEC: begin
                // Strobe is already on the bus this cycle
                if (opc_q == OPC_WR) begin
                    ser_load = 1'b1;
                    ser_buf  = {8'h00, 8'h00, 8'h00, ST_OK, addr_q, SYNC_RPL};
                    state_d  = S_REPLY;
                end else begin
                    state_d = S_RWAIT;
                end
            end
            S_RWAIT: begin
                // reg_rdata is valid now; the serializer captures it directly
                ser_load = 1'b1;
                ser_len  = RPL_LEN_LONG;
                ser_buf  = {bus.reg_rdata, addr_q, SYNC_RPL};
                state_d  = S_REPLY;
            end
            S_REPLY: begin
                if (ser_done) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_REPLY;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (timed_out) begin
            state_d = S_IDLE;
            tocnt_d = (tocnt_q == 8'hFF) ? tocnt_q : (tocnt_q + 8'd1);
        end else begin
            tocnt_d = tocnt_q;
        end
    end

    // Engine state, latched command fields and registered register strobes
    always_ff @(posedge fx2_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            opc_q    <= 8'h00;
            addr_q   <= 8'h00;
            wdata_q  <= 32'h0000_0000;
            bidx_q   <= 2'd0;
            tcnt_q   <= '0;
            tocnt_q  <= 8'h00;
            reg_wr_q <= 1'b0;
            reg_rd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            opc_q    <= opc_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            bidx_q   <= bidx_d;
            tcnt_q   <= tcnt_d;
            tocnt_q  <= tocnt_d;
            reg_wr_q <= reg_wr_d;
            reg_rd_q <= reg_rd_d;
        end
    end

    reply_serializer u_ser (
        .clk       (fx2_clk),
        .rst_n     (rst_n),
        .load      (ser_load),
        .load_buf  (ser_buf),
        .load_len  (ser_len),
        .reply_ack (bus.reply_ack),
        .reply     (bus.reply),
        .reply_rdy (bus.reply_rdy),
        .reply_end (bus.reply_end),
        .done      (ser_done)
    );

    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_wr    = reg_wr_q;
    assign bus.reg_rd    = reg_rd_q;
    assign timeout_cnt   = tocnt_q;
endmodule
